// File: rtl/game_stats_timer.sv
// Play-time and key-press statistics for the game: prescaled seconds counter (up/down with
// time-out), saturating key counter, optional BCD min:sec readout enabled by GAME_TIMER_BCD_EN.
module game_stats_timer #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned SEC_W    = 12,
    parameter int unsigned KEY_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       game_status,
    input  logic             ps2_key_pressed,
    input  logic             count_down,
    input  logic [SEC_W-1:0] time_limit,
    output logic [SEC_W-1:0] elapsed_sec,
    output logic [SEC_W-1:0] remain_sec,
    output logic [KEY_W-1:0] key_cnt,
    output logic             tick_1hz,
    output logic             time_up,
    output logic [7:0]       bcd_min,
    output logic [7:0]       bcd_sec
);

    localparam int unsigned      PRE_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);
    localparam logic [KEY_W-1:0] KEY_MAX = '1;
    localparam logic [2:0]       ST_PLAYING = 3'd2;
    localparam logic [2:0]       ST_OVER    = 3'd3;
    localparam logic [2:0]       ST_PAUSED  = 3'd4;

    logic [PRE_W-1:0] prescale;
    logic [2:0]       status_d;
    logic             ps2_key_d;
    logic             mode_cd;

    logic playing_c, paused_c, over_c, start_c, key_rise_c, wrap_c;

    // Status decode; a start is entering PLAYING from anything but PLAYING/PAUSED
    always_comb begin
        playing_c  = (game_status == ST_PLAYING);
        paused_c   = (game_status == ST_PAUSED);
        over_c     = (game_status == ST_OVER);
        start_c    = playing_c && (status_d != ST_PLAYING) && (status_d != ST_PAUSED);
        key_rise_c = ps2_key_pressed & ~ps2_key_d;
        wrap_c     = (prescale == PRE_MAX);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale    <= '0;
            status_d    <= '0;
            ps2_key_d   <= 1'b0;
            mode_cd     <= 1'b0;
            elapsed_sec <= '0;
            remain_sec  <= '0;
            key_cnt     <= '0;
            tick_1hz    <= 1'b0;
            time_up     <= 1'b0;
        end else begin
            status_d  <= game_status;
            ps2_key_d <= ps2_key_pressed;
            tick_1hz  <= 1'b0;
            if (start_c) begin
                mode_cd     <= count_down;
                remain_sec  <= count_down ? time_limit : '0;
                elapsed_sec <= '0;
                key_cnt     <= '0;
                prescale    <= '0;
                time_up     <= 1'b0;
            end else if (playing_c) begin
                if (!time_up) begin
                    // A zero remaining count at this point only arises from a zero time limit
                    if (mode_cd && (remain_sec == '0)) begin
                        time_up <= 1'b1;
                    end else if (wrap_c) begin
                        prescale    <= '0;
                        elapsed_sec <= elapsed_sec + SEC_W'(1);
                        tick_1hz    <= 1'b1;
                        if (mode_cd) begin
                            remain_sec <= remain_sec - SEC_W'(1);
                            if (remain_sec == SEC_W'(1)) time_up <= 1'b1;
                        end
                    end else begin
                        prescale <= prescale + PRE_W'(1);
                    end
                    if (key_rise_c && (key_cnt != KEY_MAX)) key_cnt <= key_cnt + KEY_W'(1);
                end
            end else if (over_c) begin
                prescale <= '0;
            end else if (!paused_c) begin
                prescale    <= '0;
                elapsed_sec <= '0;
                remain_sec  <= '0;
                key_cnt     <= '0;
                time_up     <= 1'b0;
            end
        end
    end

`ifdef GAME_TIMER_BCD_EN
    localparam int unsigned CNT_W = $clog2(SEC_W + 1);

    logic [SEC_W-1:0] bcd_last, div_num, div_quo, bcd_src_c, min_bin_c;
    logic [6:0]       div_rem;
    logic [CNT_W-1:0] div_cnt;
    logic             div_busy, div_done;
    logic [7:0]       trial_c, trial_sub_c;
    logic             trial_ge_c;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [14:0] s;
        s = {8'd0, v};
        for (int i = 0; i < 7; i++) begin
            if (s[10:7] >= 4'd5) s[10:7] = s[10:7] + 4'd3;
            if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
            s = s << 1;
        end
        return s[14:7];
    endfunction

    // One restoring-division step by 60 per cycle; quotient = minutes, remainder = seconds
    always_comb begin
        bcd_src_c   = mode_cd ? remain_sec : elapsed_sec;
        trial_c     = {div_rem, div_num[SEC_W-1]};
        trial_ge_c  = (trial_c >= 8'd60);
        trial_sub_c = trial_c - 8'd60;
        min_bin_c   = (div_quo > SEC_W'(99)) ? SEC_W'(99) : div_quo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd_last <= '0;
            div_num  <= '0;
            div_quo  <= '0;
            div_rem  <= '0;
            div_cnt  <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            bcd_min  <= 8'h00;
            bcd_sec  <= 8'h00;
        end else begin
            div_done <= 1'b0;
            if (div_busy) begin
                div_rem  <= 7'(trial_ge_c ? trial_sub_c : trial_c);
                div_quo  <= {div_quo[SEC_W-2:0], trial_ge_c};
                div_num  <= div_num << 1;
                div_cnt  <= div_cnt - CNT_W'(1);
                if (div_cnt == CNT_W'(1)) begin
                    div_busy <= 1'b0;
                    div_done <= 1'b1;
                end
            end else if (div_done) begin
                bcd_min <= to_bcd(7'(min_bin_c));
                bcd_sec <= to_bcd(div_rem);
            end else if (bcd_src_c != bcd_last) begin
                bcd_last <= bcd_src_c;
                div_num  <= bcd_src_c;
                div_quo  <= '0;
                div_rem  <= '0;
                div_cnt  <= CNT_W'(SEC_W);
                div_busy <= 1'b1;
            end
        end
    end
`else
    assign bcd_min = 8'h00;
    assign bcd_sec = 8'h00;
`endif

endmodule

// File: tb/tb_game_stats_timer.sv
// Directed self-checking bench for game_stats_timer at CLK_FREQ=10 (plus a KEY_W=2 copy).
module tb_game_stats_timer;

    localparam int unsigned SEC_W = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       game_status;
    logic             ps2_key_pressed;
    logic             count_down;
    logic [SEC_W-1:0] time_limit;

    logic [SEC_W-1:0] elapsed_sec, remain_sec, s_elapsed, s_remain;
    logic [7:0]       key_cnt, bcd_min, bcd_sec, s_bcd_min, s_bcd_sec;
    logic [1:0]       s_key_cnt;
    logic             tick_1hz, time_up, s_tick, s_time_up;

    int checks   = 0;
    int failures = 0;
    int nt, first_i, last_i;

    always #5 clk = ~clk;

    game_stats_timer #(.CLK_FREQ(10), .SEC_W(SEC_W), .KEY_W(8)) dut (
        .clock(clk), .reset(reset), .game_status(game_status),
        .ps2_key_pressed(ps2_key_pressed), .count_down(count_down), .time_limit(time_limit),
        .elapsed_sec(elapsed_sec), .remain_sec(remain_sec), .key_cnt(key_cnt),
        .tick_1hz(tick_1hz), .time_up(time_up), .bcd_min(bcd_min), .bcd_sec(bcd_sec)
    );

    game_stats_timer #(.CLK_FREQ(10), .SEC_W(SEC_W), .KEY_W(2)) dut_sat (
        .clock(clk), .reset(reset), .game_status(game_status),
        .ps2_key_pressed(ps2_key_pressed), .count_down(count_down), .time_limit(time_limit),
        .elapsed_sec(s_elapsed), .remain_sec(s_remain), .key_cnt(s_key_cnt),
        .tick_1hz(s_tick), .time_up(s_time_up), .bcd_min(s_bcd_min), .bcd_sec(s_bcd_sec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_elapsed"}, 32'(elapsed_sec), 0);
        chk({tag, "_remain"}, 32'(remain_sec), 0);
        chk({tag, "_keys"}, 32'(key_cnt), 0);
        chk({tag, "_tick"}, 32'(tick_1hz), 0);
        chk({tag, "_timeup"}, 32'(time_up), 0);
        chk({tag, "_bcd"}, {16'd0, bcd_min, bcd_sec}, 0);
    endtask

    task automatic press(input int n);
        for (int k = 0; k < n; k++) begin
            ps2_key_pressed = 1'b1;
            cyc(3);
            ps2_key_pressed = 1'b0;
            cyc(2);
        end
    endtask

    task automatic run_ticks(input int n);
        nt = 0; first_i = 0; last_i = 0;
        for (int i = 1; i <= n; i++) begin
            cyc(1);
            if (tick_1hz) begin
                nt++;
                if (first_i == 0) first_i = i;
                last_i = i;
            end
        end
    endtask

    initial begin
        reset = 1'b0; game_status = 3'd0; ps2_key_pressed = 1'b0;
        count_down = 1'b0; time_limit = '0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        chk_zero("reset");

        // Count-up: start edge then ticks every 10 edges
        game_status = 3'd2;
        run_ticks(35);
        chk("up_tick_count", 32'(nt), 3);
        chk("up_tick_first", 32'(first_i), 11);
        chk("up_tick_last", 32'(last_i), 31);
        chk("up_elapsed", 32'(elapsed_sec), 3);
        chk("up_remain", 32'(remain_sec), 0);
        game_status = 3'd3;
        cyc(5);
        chk("over_hold", 32'(elapsed_sec), 3);
        chk("over_tick", 32'(tick_1hz), 0);
        game_status = 3'd0;
        cyc(1);
        chk("idle_clear", 32'(elapsed_sec), 0);

        // Asynchronous reset mid-count
        game_status = 3'd2;
        cyc(31);
        chk("pre_reset_elapsed", 32'(elapsed_sec), 3);
        #2 reset = 1'b0;
        #1 chk_zero("async_reset");
        game_status = 3'd0;
        cyc(2);
        reset = 1'b1;
        cyc(5);
        chk_zero("idle_hold");

        // Pause holds prescaler phase mid-second
        game_status = 3'd2;
        cyc(15);
        chk("pause_pre_elapsed", 32'(elapsed_sec), 1);
        game_status = 3'd4;
        cyc(40);
        chk("pause_hold", 32'(elapsed_sec), 1);
        game_status = 3'd2;
        run_ticks(6);
        chk("resume_tick_count", 32'(nt), 1);
        chk("resume_tick_at", 32'(first_i), 6);
        chk("resume_elapsed", 32'(elapsed_sec), 2);
        game_status = 3'd0;
        cyc(1);

        // Keys: edge counting, pause blocking, saturation
        game_status = 3'd2;
        cyc(1);
        press(5);
        chk("keys_5", 32'(key_cnt), 5);
        chk("keys_sat_3", 32'(s_key_cnt), 3);
        game_status = 3'd4;
        press(2);
        chk("keys_paused", 32'(key_cnt), 5);
        game_status = 3'd2;
        press(1);
        chk("keys_6", 32'(key_cnt), 6);
        chk("keys_sat_hold", 32'(s_key_cnt), 3);
        game_status = 3'd0;
        cyc(1);
        chk("keys_idle_clear", 32'(key_cnt), 0);
        game_status = 3'd2;
        ps2_key_pressed = 1'b1;
        cyc(3);
        chk("keys_start_rise", 32'(key_cnt), 0);
        ps2_key_pressed = 1'b0;
        game_status = 3'd0;
        cyc(1);

        // Count-down expiry
        count_down = 1'b1; time_limit = 12'd2; game_status = 3'd2;
        cyc(1);
        chk("cd_load", 32'(remain_sec), 2);
        chk("cd_load_timeup", 32'(time_up), 0);
        cyc(10);
        chk("cd_remain1", 32'(remain_sec), 1);
        chk("cd_elapsed1", 32'(elapsed_sec), 1);
        cyc(10);
        chk("cd_remain0", 32'(remain_sec), 0);
        chk("cd_timeup", 32'(time_up), 1);
        chk("cd_last_tick", 32'(tick_1hz), 1);
        press(1);
        cyc(35);
        chk("cd_elapsed_stop", 32'(elapsed_sec), 2);
        chk("cd_timeup_sticky", 32'(time_up), 1);
        chk("cd_keys_blocked", 32'(key_cnt), 0);
        game_status = 3'd0;
        cyc(1);
        chk("cd_idle_clear", 32'(time_up), 0);
        time_limit = 12'd0; game_status = 3'd2;
        cyc(1);
        chk("cd_zero_start", 32'(time_up), 0);
        cyc(1);
        chk("cd_zero_timeup", 32'(time_up), 1);
        game_status = 3'd0;
        cyc(1);

        // Long count-up for the BCD readout
        count_down = 1'b0; game_status = 3'd2;
        cyc(751);
        chk("long_elapsed", 32'(elapsed_sec), 75);
        game_status = 3'd3;
        cyc(SEC_W + 4);
`ifdef GAME_TIMER_BCD_EN
        chk("bcd_min", 32'(bcd_min), 32'h01);
        chk("bcd_sec", 32'(bcd_sec), 32'h15);
`else
        chk("bcd_min_off", 32'(bcd_min), 0);
        chk("bcd_sec_off", 32'(bcd_sec), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
